// File: rtl/ifetch_stage_pkg.sv
// +--------------------------------------------------------------------------+
// | ifetch_stage_pkg : shared constants and FSM state encoding for the fetch |
// | stage.                                                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package ifetch_stage_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifetch_skid.sv
// +--------------------------------------------------------------------------+
// | ifetch_skid : one-entry pc+instruction holding register, load and clear. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ifetch_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          clear_i,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] instr_i,
    output logic          valid_o,
    output logic [DW-1:0] pc_o,
    output logic [DW-1:0] instr_o
);

    logic          valid_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
// +--------------------------------------------------------------------------+
// | ifetch_stage : fetch stage with IF/ID register, stall, redirect/flush    |
// | and a one-entry skid buffer. Optional IFETCH_MISALIGN_CHK_EN adds        |
// | misaligned-PC trapping via id_misalign.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ifetch_stage #(
    parameter int             DW        = 32,
    parameter logic [DW-1:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc_in,
    output logic [DW-1:0] pc_new,
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc,
    output logic          id_valid,
    output logic [DW-1:0] id_pc,
    output logic [DW-1:0] id_instr
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic          id_misalign
`endif
);

    import ifetch_stage_pkg::fetch_state_e;
    import ifetch_stage_pkg::ST_RUN;
    import ifetch_stage_pkg::ST_HOLD;
    import ifetch_stage_pkg::ST_KILL;
    import ifetch_stage_pkg::ZERO_WORD;

    fetch_state_e  state_q, state_d;
    logic          id_valid_q, id_valid_d;
    logic [DW-1:0] id_pc_q, id_pc_d;
    logic [DW-1:0] id_instr_q, id_instr_d;
    logic [DW-1:0] redir_q, redir_d;

    logic          w_accept;
    logic          w_ack;
    logic          w_mis_pc;
    logic          w_mis_hold;
    logic          w_skid_load;
    logic          w_skid_clear;
    logic          w_skid_valid;
    logic [DW-1:0] w_skid_pc;
    logic [DW-1:0] w_skid_instr;
    logic [DW-1:0] w_pc_plus4;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic          misalign_q, misalign_d;
    assign w_mis_hold  = misalign_q;
    assign w_mis_pc    = (state_q == ST_RUN) && (pc_in[1:0] != 2'b00);
    assign id_misalign = misalign_q;
`else
    assign w_mis_hold  = 1'b0;
    assign w_mis_pc    = 1'b0;
`endif

    assign w_accept   = !id_valid_q || !stall_i;
    assign imem_req   = !rst && (state_q != ST_HOLD) && !w_mis_pc && !w_mis_hold;
    assign imem_addr  = {pc_in[DW-1:2], 2'b00};
    assign w_ack      = imem_req && imem_ack;
    assign w_pc_plus4 = pc_in + DW'(4);

    always_comb begin
        state_d      = state_q;
        pc_new       = pc_in;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        redir_d      = redir_q;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (w_mis_hold || w_mis_pc) begin
                    // No request is outstanding, so a redirect applies directly.
                    if (redirect_i) begin
                        pc_new     = redirect_pc;
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
                        misalign_d = 1'b0;
`endif
                    end else if (!w_mis_hold && w_accept) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_in;
                        id_instr_d = NOP_INSTR;
`ifdef IFETCH_MISALIGN_CHK_EN
                        misalign_d = 1'b1;
`endif
                    end
                end else if (w_ack) begin
                    if (redirect_i) begin
                        pc_new     = redirect_pc;
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end else if (w_accept) begin
                        pc_new     = w_pc_plus4;
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_in;
                        id_instr_d = imem_rdata;
                    end else begin
                        pc_new      = w_pc_plus4;
                        w_skid_load = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end else if (redirect_i) begin
                    redir_d    = redirect_pc;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = ST_KILL;
                end else if (w_accept) begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    pc_new       = redirect_pc;
                    w_skid_clear = 1'b1;
                    id_valid_d   = 1'b0;
                    id_instr_d   = NOP_INSTR;
                    state_d      = ST_RUN;
                end else if (!stall_i) begin
                    id_valid_d   = w_skid_valid;
                    id_pc_d      = w_skid_pc;
                    id_instr_d   = w_skid_instr;
                    w_skid_clear = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_KILL: begin
                // Old request must complete on its stable address before the jump.
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                if (w_ack) begin
                    pc_new  = redirect_i ? redirect_pc : redir_q;
                    state_d = ST_RUN;
                end else if (redirect_i) begin
                    redir_d = redirect_pc;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            id_valid_q <= 1'b0;
            id_pc_q    <= DW'(ZERO_WORD);
            id_instr_q <= NOP_INSTR;
            redir_q    <= DW'(ZERO_WORD);
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            redir_q    <= redir_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    ifetch_skid #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_skid_load),
        .clear_i (w_skid_clear),
        .pc_i    (pc_in),
        .instr_i (imem_rdata),
        .valid_o (w_skid_valid),
        .pc_o    (w_skid_pc),
        .instr_o (w_skid_instr)
    );

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_stage.sv
// +--------------------------------------------------------------------------+
// | tb_ifetch_stage : directed self-checking bench for ifetch_stage, with a  |
// | PC register model that loads pc_new each clock.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_r;
    logic [31:0] pc_new;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        id_misalign;
`endif

    logic        pc_ovr_en = 1'b0;
    logic [31:0] pc_ovr = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    ifetch_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_r),
        .pc_new      (pc_new),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall_i     (stall_i),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .id_misalign (id_misalign)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) pc_r <= 32'h0;
        else     pc_r <= pc_ovr_en ? pc_ovr : pc_new;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h13);
        tick();
        rst = 1'b0;

        // 1: back-to-back acks from pc 0
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000; #1;
        chk("t1_req", {31'b0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_pcnew0", pc_new, 32'h4);
        tick();
        chk("t1_valid0", {31'b0, id_valid}, 32'h1);
        chk("t1_idpc0", id_pc, 32'h0);
        chk("t1_instr0", id_instr, 32'hA000_0000);
        imem_rdata = 32'hA000_0001; #1;
        chk("t1_pcnew1", pc_new, 32'h8);
        tick();
        chk("t1_idpc1", id_pc, 32'h4);
        chk("t1_instr1", id_instr, 32'hA000_0001);
        imem_rdata = 32'hA000_0002;
        tick();
        chk("t1_idpc2", id_pc, 32'h8);

        // 2: ack delayed three cycles at pc 12
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_addr", imem_addr, 32'hC);
            chk("t2_pcnew", pc_new, 32'hC);
            tick();
            chk("t2_valid", {31'b0, id_valid}, 32'h0);
        end
        imem_ack = 1'b1; imem_rdata = 32'hB000_0000;
        tick();
        chk("t2_valid_ack", {31'b0, id_valid}, 32'h1);
        chk("t2_idpc", id_pc, 32'hC);
        chk("t2_instr", id_instr, 32'hB000_0000);

        // 3: stall with live ID entry -> HOLD, then release
        stall_i = 1'b1; imem_rdata = 32'hC000_0000; #1;
        chk("t3_pcnew", pc_new, 32'h14);
        tick();
        imem_ack = 1'b0; #1;
        chk("t3_req_hold", {31'b0, imem_req}, 32'h0);
        chk("t3_idpc_hold", id_pc, 32'hC);
        chk("t3_instr_hold", id_instr, 32'hB000_0000);
        chk("t3_pcnew_hold", pc_new, 32'h14);
        tick();
        chk("t3_req_hold2", {31'b0, imem_req}, 32'h0);
        chk("t3_idpc_hold2", id_pc, 32'hC);
        stall_i = 1'b0;
        tick();
        chk("t3_valid_rel", {31'b0, id_valid}, 32'h1);
        chk("t3_idpc_rel", id_pc, 32'h10);
        chk("t3_instr_rel", id_instr, 32'hC000_0000);
        chk("t3_req_rel", {31'b0, imem_req}, 32'h1);
        chk("t3_addr_rel", imem_addr, 32'h14);
        imem_ack = 1'b1; imem_rdata = 32'hC000_0001;
        tick();
        chk("t3_idpc_next", id_pc, 32'h14);
        chk("t3_instr_next", id_instr, 32'hC000_0001);

        // 4: redirect while request pending at 0x20
        imem_ack = 1'b0; pc_ovr_en = 1'b1; pc_ovr = 32'h20;
        tick();
        pc_ovr_en = 1'b0;
        redirect_i = 1'b1; redirect_pc = 32'h100; #1;
        chk("t4_pcnew_redir", pc_new, 32'h20);
        tick();
        redirect_i = 1'b0; #1;
        chk("t4_req_kill", {31'b0, imem_req}, 32'h1);
        chk("t4_addr_kill", imem_addr, 32'h20);
        chk("t4_pcnew_kill", pc_new, 32'h20);
        chk("t4_valid_kill", {31'b0, id_valid}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        chk("t4_pcnew_ack", pc_new, 32'h100);
        tick();
        imem_ack = 1'b0; #1;
        chk("t4_valid_after", {31'b0, id_valid}, 32'h0);
        chk("t4_addr_after", imem_addr, 32'h100);
        chk("t4_instr_after", id_instr, 32'h13);

        // 5: PC wrap
        pc_ovr_en = 1'b1; pc_ovr = 32'hFFFF_FFFC;
        tick();
        pc_ovr_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hE000_0000; #1;
        chk("t5_pcnew_wrap", pc_new, 32'h0);
        tick();
        imem_ack = 1'b0; #1;
        chk("t5_idpc", id_pc, 32'hFFFF_FFFC);
        chk("t5_pc_in", pc_r, 32'h0);

        // Asynchronous reset mid-request
        rst = 1'b1; #1;
        chk("rst_mid_req", {31'b0, imem_req}, 32'h0);
        chk("rst_mid_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_mid_instr", id_instr, 32'h13);
        tick();
        rst = 1'b0;

`ifdef IFETCH_MISALIGN_CHK_EN
        // 6: redirect to a misaligned target
        imem_ack = 1'b1; redirect_i = 1'b1; redirect_pc = 32'h102; #1;
        chk("t6_pcnew_redir", pc_new, 32'h102);
        tick();
        imem_ack = 1'b0; redirect_i = 1'b0; #1;
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        chk("t6_pcnew", pc_new, 32'h102);
        tick();
        chk("t6_misalign", {31'b0, id_misalign}, 32'h1);
        chk("t6_valid", {31'b0, id_valid}, 32'h1);
        chk("t6_instr", id_instr, 32'h13);
        chk("t6_idpc", id_pc, 32'h102);
        tick();
        chk("t6_hold_req", {31'b0, imem_req}, 32'h0);
        chk("t6_hold_mis", {31'b0, id_misalign}, 32'h1);
        redirect_i = 1'b1; redirect_pc = 32'h200; #1;
        chk("t6_pcnew_exit", pc_new, 32'h200);
        tick();
        redirect_i = 1'b0; #1;
        chk("t6_mis_clear", {31'b0, id_misalign}, 32'h0);
        chk("t6_valid_clear", {31'b0, id_valid}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
